tetris_grid_renderer: RTL
=========================

# tetris_grid_renderer

Pixel-domain renderer that turns the game logic's playfield rows into VGA colour. It sits directly downstream of the game-logic FSM and consumes its row-write stream (grid address + 10-bit line data) and current state code. It double-buffers the 20×10 playfield so the picture never tears mid-frame. It produces registered RGB444 plus a delayed display-enable for the video timing/output stage.

## Interface
- CELL_SHIFT, 4: log2 of cell size in pixels (16×16 cells).
- GRID_X0, 240: left pixel column of the playfield interior.
- GRID_Y0, 80: top pixel row of the playfield interior.
- BORDER_PX, 4: width of the border ring outside the interior.
- COL_BG, 12'h000: empty-cell colour.
- COL_FG, 12'h0CF: filled-cell colour.
- COL_BORDER, 12'h888: border colour.
- COL_OVER, 12'hF00: filled-cell colour in the game-over state.

Ports:
- i_pixclk  in  1  pixel clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_grid_we  in  1  row write strobe, one row per asserted cycle.
- i_grid_address  in  5  row index; 0 is the top row and 19 is the bottom row.
- i_grid_line_data  in  10  row contents; bit 0 is the leftmost column and 1 means filled.
- i_grid_clr  in  1  clears the back buffer.
- i_frame_start  in  1  one-cycle pulse at vblank start that swaps the buffers.
- i_c_state  in  4  game state code from the FSM.
- i_hcount  in  10  current pixel column.
- i_vcount  in  10  current pixel row.
- i_de  in  1  active-video enable aligned with i_hcount and i_vcount.
- o_rgb  out  12  RGB444 pixel; value is {R,G,B}.
- o_de  out  1  i_de delayed to align with o_rgb.

## Operation
- **Back buffer.** The back buffer is 20×10 bits and is the write target.
  - If i_grid_we is high and i_grid_address < 20, the addressed row takes i_grid_line_data.
  - Addresses 20–31 are ignored.
- **Clear.** i_grid_clr zeroes all back rows in one cycle.
  - It has priority over a write in the same cycle.
- **Front buffer.** The front buffer is 20×10 bits and is the only source for rendering.
  - On i_frame_start, every front row takes the back row's value from before this cycle's write or clear.
  - A write or clear in the swap cycle lands in the back buffer only, so it becomes visible after the next swap.
- **Pixel classification.** Use local coordinates lx = i_hcount − GRID_X0 and ly = i_vcount − GRID_Y0, computed 11-bit signed.
  - Interior: 0 ≤ lx < 10<<CELL_SHIFT and 0 ≤ ly < 20<<CELL_SHIFT. Then col = lx>>CELL_SHIFT and row = ly>>CELL_SHIFT.
  - Border: within BORDER_PX of the interior on any side, and not interior.
  - Outside: everything else.
- **Colour selection.**
  - Not de: 12'h000.
  - Outside: COL_BG.
  - Border: COL_BORDER.
  - Interior in lobby state (4'b0000): COL_BG.
  - Interior, filled cell, state 4'b1000 (game over): COL_OVER.
  - Interior, filled cell, any other state: COL_FG.
  - Interior, empty cell: COL_BG.
- **Reset.** Both buffers, all pipeline registers, o_rgb and o_de go to 0.
  - Reset mid-frame blanks the output immediately.
  - After release, output resumes on the third valid clock with empty buffers.

## Timing
- Pipeline latency is 2 cycles.
  - Stage 1 registers de, the region class, row/col, and i_c_state.
  - Stage 2 indexes the front buffer and registers o_rgb and o_de.
- o_de(t) = i_de(t−2). o_rgb corresponds to i_hcount/i_vcount from cycle t−2.
- A front-buffer update at edge t affects stage-2 lookups from cycle t+1.
  - Because the swap occurs in vblank, no visible pixel mixes two frames.
- There is no backpressure. Every cycle accepts a write and a pixel.

## Configuration
- **Without TETRIS_GRID_LINES_EN:** cells are drawn solid.
- **With TETRIS_GRID_LINES_EN:**
  - Interior pixels whose lx or ly low CELL_SHIFT bits equal 0 output COL_BORDER, regardless of cell contents.
  - Latency and all other behaviour are unchanged.

## Structure
- **Shared package tetris_pkg** holds:
  - game-state localparams (S_LOBBY = 4'b0000 … S_GAME_OVER = 4'b1000, S_COLLISION_CHECK = 4'b1001);
  - GRID_ROWS = 20 and GRID_COLS = 10;
  - the RGB444 colour type width (12).
- **Sub-module tetris_grid_buffer** owns the back and front arrays, the write/clear/swap logic, and a combinational row-read port.
- **The renderer** owns classification, the pipeline, and colour muxing.

## Test plan
- **Basic render.**
  - Stimulus: write row 19 = 10'b1000000001, pulse i_frame_start, state 4'b0010, drive pixel (240, 80+19·16 = 384) with de = 1.
  - Response: o_rgb = 12'h0CF two cycles later.
  - Stimulus: drive pixel (256, 384).
  - Response: 12'h000.
- **Buffering.** Write row 0 = 10'h3FF without a swap, then render (240, 80).
  - Before any swap: COL_BG.
  - After one i_frame_start pulse: COL_FG.
- **Simultaneous events.**
  - Write row 5 in the same cycle as i_frame_start → row 5 stays empty in front.
  - Next swap → row 5 shows.
  - i_grid_clr together with i_grid_we → back buffer all zero.
  - Write to address 20 → no change to any row.
- **States and border.**
  - Filled cell with state 4'b1000 → 12'hF00.
  - Same cell with state 4'b0000 → 12'h000.
  - Pixel (238, 200) → COL_BORDER.
  - Pixel (230, 200) → 12'h000.
  - Pixel with i_de = 0 → o_rgb = 0 and o_de = 0.
- **Reset mid-frame.**
  - Assert i_reset_n low with the buffers populated → o_rgb = 0 and o_de = 0 asynchronously.
  - After release, all cells render COL_BG until new writes and a swap.
- **With TETRIS_GRID_LINES_EN.** With row 0 filled:
  - Pixel (240, 85) → COL_BORDER.
  - Pixel (245, 85) → COL_FG.
  - Same two pixels without the macro → both COL_FG.

Source files
------------

// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared game-state codes, grid geometry and colour types
package tetris_pkg;

    localparam logic [3:0] S_LOBBY           = 4'b0000;
    localparam logic [3:0] S_GAME_OVER       = 4'b1000;
    localparam logic [3:0] S_COLLISION_CHECK = 4'b1001;

    localparam int GRID_ROWS = 20;
    localparam int GRID_COLS = 10;
    localparam int RGB_W     = 12;

    typedef logic [RGB_W-1:0]     rgb_t;
    typedef logic [GRID_COLS-1:0] row_t;

    typedef enum logic [1:0] {
        RGN_OUTSIDE  = 2'd0,
        RGN_BORDER   = 2'd1,
        RGN_INTERIOR = 2'd2
    } region_t;

endpackage

// File: rtl/tetris_grid_buffer.sv
// rtl/tetris_grid_buffer.sv - double-buffered 20x10 playfield store
// Ports: i_pixclk/i_reset_n clock and async active-low reset;
//        i_grid_we/i_grid_address/i_grid_line_data back-buffer row write;
//        i_grid_clr clears back buffer; i_frame_start copies back to front;
//        i_rd_row/o_rd_data combinational front-buffer row read.
module tetris_grid_buffer
    import tetris_pkg::*;
(
    input  logic       i_pixclk,
    input  logic       i_reset_n,
    input  logic       i_grid_we,
    input  logic [4:0] i_grid_address,
    input  logic [9:0] i_grid_line_data,
    input  logic       i_grid_clr,
    input  logic       i_frame_start,
    input  logic [4:0] i_rd_row,
    output row_t       o_rd_data
);

    row_t r_back  [GRID_ROWS];
    row_t r_front [GRID_ROWS];

    // The swap samples r_back before this edge's write/clear lands, so a
    // write in the swap cycle only shows after the following swap.
    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < GRID_ROWS; i++) begin
                r_back[i]  <= '0;
                r_front[i] <= '0;
            end
        end else begin
            if (i_frame_start) begin
                for (int i = 0; i < GRID_ROWS; i++) begin
                    r_front[i] <= r_back[i];
                end
            end
            if (i_grid_clr) begin
                for (int i = 0; i < GRID_ROWS; i++) begin
                    r_back[i] <= '0;
                end
            end else if (i_grid_we && (i_grid_address < 5'(GRID_ROWS))) begin
                r_back[i_grid_address] <= i_grid_line_data;
            end
        end
    end

    assign o_rd_data = (i_rd_row < 5'(GRID_ROWS)) ? r_front[i_rd_row] : '0;

endmodule

// File: rtl/tetris_grid_renderer.sv
// rtl/tetris_grid_renderer.sv - playfield to RGB444 renderer, 2-cycle pipeline
// Ports: i_pixclk/i_reset_n clock and async active-low reset;
//        i_grid_we/i_grid_address/i_grid_line_data/i_grid_clr/i_frame_start
//        playfield row stream and buffer control; i_c_state game state;
//        i_hcount/i_vcount/i_de pixel position and enable;
//        o_rgb registered {R,G,B}; o_de enable aligned with o_rgb.
// Optional: TETRIS_GRID_LINES_EN draws cell outlines in the border colour.
module tetris_grid_renderer
    import tetris_pkg::*;
#(
    parameter int   CELL_SHIFT = 4,
    parameter int   GRID_X0    = 240,
    parameter int   GRID_Y0    = 80,
    parameter int   BORDER_PX  = 4,
    parameter rgb_t COL_BG     = 12'h000,
    parameter rgb_t COL_FG     = 12'h0CF,
    parameter rgb_t COL_BORDER = 12'h888,
    parameter rgb_t COL_OVER   = 12'hF00
) (
    input  logic        i_pixclk,
    input  logic        i_reset_n,
    input  logic        i_grid_we,
    input  logic [4:0]  i_grid_address,
    input  logic [9:0]  i_grid_line_data,
    input  logic        i_grid_clr,
    input  logic        i_frame_start,
    input  logic [3:0]  i_c_state,
    input  logic [9:0]  i_hcount,
    input  logic [9:0]  i_vcount,
    input  logic        i_de,
    output logic [11:0] o_rgb,
    output logic        o_de
);

    localparam int L_W = GRID_COLS << CELL_SHIFT;
    localparam int L_H = GRID_ROWS << CELL_SHIFT;

    logic signed [10:0] w_lx, w_ly;
    int                 w_lxi, w_lyi;
    logic               w_in_x, w_in_y, w_ring_x, w_ring_y;
    region_t            w_region;
    row_t               w_row_data;
    rgb_t               w_rgb_next;

    logic        r_de1;
    region_t     r_region1;
    logic [4:0]  r_row1;
    logic [3:0]  r_col1;
    logic [3:0]  r_state1;
`ifdef TETRIS_GRID_LINES_EN
    logic        r_gline1;
`endif

    assign w_lx  = $signed({1'b0, i_hcount}) - $signed(11'(GRID_X0));
    assign w_ly  = $signed({1'b0, i_vcount}) - $signed(11'(GRID_Y0));
    assign w_lxi = int'(w_lx);
    assign w_lyi = int'(w_ly);

    always_comb begin
        w_in_x   = (w_lxi >= 0) && (w_lxi < L_W);
        w_in_y   = (w_lyi >= 0) && (w_lyi < L_H);
        // Interior grown by BORDER_PX on every side; the ring is this minus the interior.
        w_ring_x = (w_lxi >= -BORDER_PX) && (w_lxi < L_W + BORDER_PX);
        w_ring_y = (w_lyi >= -BORDER_PX) && (w_lyi < L_H + BORDER_PX);
        w_region = RGN_OUTSIDE;
        if (w_in_x && w_in_y) begin
            w_region = RGN_INTERIOR;
        end else if (w_ring_x && w_ring_y) begin
            w_region = RGN_BORDER;
        end
    end

    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_de1     <= 1'b0;
            r_region1 <= RGN_OUTSIDE;
            r_row1    <= '0;
            r_col1    <= '0;
            r_state1  <= '0;
`ifdef TETRIS_GRID_LINES_EN
            r_gline1  <= 1'b0;
`endif
        end else begin
            r_de1     <= i_de;
            r_region1 <= w_region;
            // Only meaningful for interior pixels, where they fit 0..19 / 0..9.
            r_row1    <= w_ly[CELL_SHIFT +: 5];
            r_col1    <= w_lx[CELL_SHIFT +: 4];
            r_state1  <= i_c_state;
`ifdef TETRIS_GRID_LINES_EN
            r_gline1  <= (w_lx[CELL_SHIFT-1:0] == '0) || (w_ly[CELL_SHIFT-1:0] == '0);
`endif
        end
    end

    tetris_grid_buffer u_buffer (
        .i_pixclk         (i_pixclk),
        .i_reset_n        (i_reset_n),
        .i_grid_we        (i_grid_we),
        .i_grid_address   (i_grid_address),
        .i_grid_line_data (i_grid_line_data),
        .i_grid_clr       (i_grid_clr),
        .i_frame_start    (i_frame_start),
        .i_rd_row         (r_row1),
        .o_rd_data        (w_row_data)
    );

    always_comb begin
        w_rgb_next = 12'h000;
        if (r_de1) begin
            case (r_region1)
                RGN_BORDER: w_rgb_next = COL_BORDER;
                RGN_INTERIOR: begin
`ifdef TETRIS_GRID_LINES_EN
                    if (r_gline1) begin
                        w_rgb_next = COL_BORDER;
                    end else
`endif
                    if (r_state1 == S_LOBBY || !w_row_data[r_col1]) begin
                        w_rgb_next = COL_BG;
                    end else if (r_state1 == S_GAME_OVER) begin
                        w_rgb_next = COL_OVER;
                    end else begin
                        w_rgb_next = COL_FG;
                    end
                end
                default: w_rgb_next = COL_BG;
            endcase
        end
    end

    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_rgb <= 12'h000;
            o_de  <= 1'b0;
        end else begin
            o_rgb <= w_rgb_next;
            o_de  <= r_de1;
        end
    end

endmodule
